cdc_handshake_tx: RTL and testbench

CDC_HANDSHAKE_TX -- requirements
Module: cdc_handshake_tx

---
 rtl/cdc_handshake_tx_pkg.sv | 15 +
 rtl/cdc_simple.sv | 27 ++
 rtl/cdc_handshake_tx.sv | 128 ++++++++++++
 tb/tb_cdc_handshake_tx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_handshake_tx_pkg.sv
// Shared constants for the four-phase source-side CDC handshake.
// The state encoding lives here so the controller and any debug decode agree on it.
package cdc_handshake_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_REQ_WAIT = 2'd2,
    ST_ACK_WAIT = 2'd3
  } hs_state_t;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_PIPE_DEPTH = 2;

endpackage

// File: rtl/cdc_simple.sv
// Single-bit level synchronizer: pPIPE_DEPTH flops in series.
// Only these flops carry the ASYNC_REG attribute.
module cdc_simple #(
  parameter int pPIPE_DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [pPIPE_DEPTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < pPIPE_DEPTH; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[pPIPE_DEPTH-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source side of a four-phase req/ack word transfer with a one-entry pending slot.
// state       | meaning
// ST_IDLE     | nothing in flight, data_out free to load
// ST_LOAD     | data_out loaded, settling one cycle before req rises
// ST_REQ_WAIT | req high, waiting for synchronized ack to rise
// ST_ACK_WAIT | req low, waiting for synchronized ack to fall
module cdc_handshake_tx
  import cdc_handshake_tx_pkg::*;
#(
  parameter int pDATA_WIDTH = DEF_DATA_WIDTH,
  parameter int pPIPE_DEPTH = DEF_PIPE_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [pDATA_WIDTH-1:0] data_in,
  input  logic                   data_valid,
  output logic                   ready,
  output logic                   req,
  output logic [pDATA_WIDTH-1:0] data_out,
  input  logic                   ack,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  hs_state_t              state, state_nx;
  logic                   ack_s;
  logic                   req_nx;
  logic [pDATA_WIDTH-1:0] data_out_nx;
  logic                   pend_valid, pend_valid_nx;
  logic [pDATA_WIDTH-1:0] pend_data, pend_data_nx;
  logic                   done_nx;
  logic                   overflow_nx;
  logic                   accept;
  logic                   direct;

  cdc_simple #(
    .pPIPE_DEPTH(pPIPE_DEPTH)
  ) u_ack_sync (
    .clk  (clk),
    .reset(reset),
    .d    (ack),
    .q    (ack_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      req        <= 1'b0;
      data_out   <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nx;
      req        <= req_nx;
      data_out   <= data_out_nx;
      pend_valid <= pend_valid_nx;
      pend_data  <= pend_data_nx;
      done       <= done_nx;
      overflow   <= overflow_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    req_nx        = req;
    data_out_nx   = data_out;
    pend_valid_nx = pend_valid;
    pend_data_nx  = pend_data;
    done_nx       = 1'b0;
    overflow_nx   = overflow;
    accept        = data_valid && !pend_valid;
    direct        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          direct   = 1'b1;
          state_nx = ST_LOAD;
        end
      end
      ST_LOAD: begin
        req_nx   = 1'b1;
        state_nx = ST_REQ_WAIT;
      end
      ST_REQ_WAIT: begin
        if (ack_s) begin
          req_nx   = 1'b0;
          state_nx = ST_ACK_WAIT;
        end
      end
      ST_ACK_WAIT: begin
        if (!ack_s) begin
          done_nx = 1'b1;
          if (pend_valid) begin
            data_out_nx   = pend_data;
            pend_valid_nx = 1'b0;
            state_nx      = ST_LOAD;
          end else if (accept) begin
            // A word arriving on the exit cycle with an empty slot goes straight out.
            direct   = 1'b1;
            state_nx = ST_LOAD;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    if (direct) begin
      data_out_nx = data_in;
    end else if (accept) begin
      pend_valid_nx = 1'b1;
      pend_data_nx  = data_in;
    end

    if (data_valid && pend_valid) begin
      overflow_nx = 1'b1;
    end
  end

  assign ready = ~pend_valid;
  assign busy  = (state != ST_IDLE) || pend_valid;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Self-checking bench for cdc_handshake_tx: directed scenarios, then random traffic
// against an occupancy-count reference model with a random-latency destination.
module tb_cdc_handshake_tx;

  localparam int W = 8;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         data_valid;
  logic         ready;
  logic         req;
  logic [W-1:0] data_out;
  logic         ack;
  logic         busy;
  logic         done;
  logic         overflow;

  cdc_handshake_tx #(
    .pDATA_WIDTH(W),
    .pPIPE_DEPTH(D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .data_valid(data_valid),
    .ready     (ready),
    .req       (req),
    .data_out  (data_out),
    .ack       (ack),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: words in the system (in flight + waiting), ack seen through D flops.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] del_q[$];
  logic [D-1:0] hist = '0;
  int  outstanding = 0;
  int  accepted_m  = 0;
  bit  acked       = 0;
  bit  ovf_m       = 0;
  bit  done_m      = 0;
  bit  acks_used   = 0;
  bit  rst_used    = 0;
  bit  complete;

  always @(posedge clk) begin
    acks_used = hist[D-1];
    rst_used  = reset;
    if (reset) begin
      hist        = '0;
      outstanding = 0;
      acked       = 0;
      ovf_m       = 0;
      done_m      = 0;
      exp_q.delete();
      del_q.delete();
    end else begin
      done_m   = 0;
      complete = acked && !acks_used && (outstanding > 0);
      if (data_valid) begin
        if (outstanding < 2) begin
          exp_q.push_back(data_in);
          outstanding++;
          accepted_m++;
        end else begin
          ovf_m = 1;
        end
      end
      if (complete) begin
        outstanding--;
        acked  = 0;
        done_m = 1;
      end
      if (acks_used && outstanding > 0) acked = 1;
      for (int i = D - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = ack;
    end
  end

  bit           chk_en = 0;
  logic         prev_req;
  logic [W-1:0] prev_dout;
  bit           changed;

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", 32'(ready), 32'(outstanding < 2));
      check("busy", 32'(busy), 32'(outstanding > 0));
      check("done", 32'(done), 32'(done_m));
      check("overflow", 32'(overflow), 32'(ovf_m));
      changed = (data_out !== prev_dout);
      check("dout_stable", 32'(changed && (prev_req || acks_used) && !rst_used), 32'(0));
      if (req && !prev_req) del_q.push_back(data_out);
      prev_req  = req;
      prev_dout = data_out;
    end
  end

  // Destination responder for the random phase.
  bit auto_ack = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (auto_ack && req === 1'b1 && ack == 1'b0) begin
        repeat ($urandom_range(1, 20)) @(negedge clk);
        ack = 1'b1;
        for (int n = 0; n < 200 && req !== 1'b0; n++) @(negedge clk);
        check("resp_req_drop", 32'(req), 32'(0));
        repeat ($urandom_range(1, 20)) @(negedge clk);
        ack = 1'b0;
      end
    end
  end

  task automatic wait_req(input logic lvl, input string tag);
    for (int n = 0; n < 60 && req !== lvl; n++) @(negedge clk);
    check(tag, 32'(req), 32'(lvl));
  endtask

  task automatic handshake(input string tag);
    wait_req(1'b1, {tag, "_req_rise"});
    ack = 1'b1;
    wait_req(1'b0, {tag, "_req_fall"});
    ack = 1'b0;
    for (int n = 0; n < 60 && done !== 1'b1; n++) @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'(1));
  endtask

  task automatic compare_queues(input string tag);
    check({tag, "_count"}, 32'(del_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < del_q.size() && i < exp_q.size(); i++)
      check({tag, "_word"}, 32'(del_q[i]), 32'(exp_q[i]));
  endtask

  int n;
  int cyc;

  initial begin
    reset      = 1'b1;
    data_in    = '0;
    data_valid = 1'b0;
    ack        = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", 32'(req), 32'(0));
    check("rst_dout", 32'(data_out), 32'(0));
    check("rst_ready", 32'(ready), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_ovf", 32'(overflow), 32'(0));
    prev_req  = req;
    prev_dout = data_out;
    chk_en    = 1;
    reset     = 1'b0;
    @(negedge clk);

    // Single word: data_out same edge, req one edge later, req drops D+1 cycles after ack.
    data_in = 8'hA5; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    check("single_dout", 32'(data_out), 32'hA5);
    check("single_req_low", 32'(req), 32'(0));
    @(negedge clk);
    check("single_req_high", 32'(req), 32'(1));
    ack = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (req && n < 20);
    check("single_req_lat", 32'(n), 32'(D + 1));
    ack = 1'b0;
    n = 0;
    repeat (8) begin @(negedge clk); if (done) n++; end
    check("single_done_pulses", 32'(n), 32'(1));
    check("single_idle", 32'(busy), 32'(0));

    // Back-to-back: second word parks in the slot and follows the first.
    data_in = 8'h11; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    @(negedge clk);
    data_in = 8'h22; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    check("b2b_ready", 32'(ready), 32'(0));
    check("b2b_dout_first", 32'(data_out), 32'h11);
    handshake("b2b_first");
    check("b2b_dout_second", 32'(data_out), 32'h22);
    check("b2b_req_low", 32'(req), 32'(0));
    @(negedge clk);
    check("b2b_req_next", 32'(req), 32'(1));
    handshake("b2b_second");
    check("b2b_ovf", 32'(overflow), 32'(0));

    // Overflow: third word dropped, flag sticky.
    data_in = 8'h11; data_valid = 1'b1;
    @(negedge clk);
    data_in = 8'h22;
    @(negedge clk);
    data_in = 8'h33;
    @(negedge clk);
    data_valid = 1'b0;
    check("ovf_set", 32'(overflow), 32'(1));
    check("ovf_ready", 32'(ready), 32'(0));
    handshake("ovf_first");
    handshake("ovf_second");
    repeat (3) @(negedge clk);
    check("ovf_sticky", 32'(overflow), 32'(1));
    check("ovf_last_dout", 32'(data_out), 32'h22);
    compare_queues("directed");

    // Reset in REQ_WAIT.
    data_in = 8'h5A; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    wait_req(1'b1, "rstmid_req_rise");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_req", 32'(req), 32'(0));
    check("rstmid_ready", 32'(ready), 32'(1));
    check("rstmid_ovf", 32'(overflow), 32'(0));
    check("rstmid_dout", 32'(data_out), 32'(0));
    n = 0;
    repeat (6) begin @(negedge clk); if (done) n++; end
    check("rstmid_no_done", 32'(n), 32'(0));

    // Spurious ack in IDLE.
    ack = 1'b1;
    n = 0;
    repeat (5) begin @(negedge clk); if (done || req || busy) n++; end
    ack = 1'b0;
    repeat (D + 3) begin @(negedge clk); if (done || req || busy) n++; end
    check("spurious_ack_quiet", 32'(n), 32'(0));

    // Random traffic with random destination latency.
    auto_ack = 1;
    cyc = 0;
    while (accepted_m < 1000 && cyc < 60000) begin
      data_in    = W'($urandom);
      data_valid = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      cyc++;
    end
    data_valid = 1'b0;
    check("rand_accepted", 32'(accepted_m >= 1000), 32'(1));
    n = 0;
    while ((outstanding != 0 || ack) && n < 3000) begin @(negedge clk); n++; end
    check("rand_drained", 32'(outstanding), 32'(0));
    auto_ack = 0;
    repeat (4) @(negedge clk);
    compare_queues("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
